// File: rtl/uart_rx_packet_assembler.sv
// uart_rx_packet_assembler
// Collects one-cycle byte strobes from the UART receiver into a fixed-length
// payload word and offers it on a valid/ready handshake. An end-of-packet
// strobe in the middle of a packet discards the partial payload and flags
// short_pkt. Bytes that arrive while a payload is held are dropped and flag
// overrun.
// Optional feature macro: RX_CHECKSUM_EN. When defined, each packet carries a
// trailing XOR checksum byte that is verified before the payload is offered.
module uart_rx_packet_assembler #(
  parameter int PAYLOAD_BYTES = 32,
  parameter int CW            = $clog2(PAYLOAD_BYTES + 2)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_data_ready,
  input  logic                       rx_endofpacket,
  output logic [8*PAYLOAD_BYTES-1:0] payload_data,
  output logic                       payload_valid,
  input  logic                       payload_ready,
  output logic [CW-1:0]              byte_count,
  output logic                       short_pkt,
  output logic                       overrun,
  output logic                       csum_error
);

  localparam int PW = 8 * PAYLOAD_BYTES;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    CSUM    = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(PAYLOAD_BYTES - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      xor_q, xor_d;
  logic            valid_q, valid_d;
  logic            short_q, short_d;
  logic            overrun_q, overrun_d;
  logic            csum_err_q, csum_err_d;

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      shreg_q    <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      xor_q      <= 8'h00;
      valid_q    <= 1'b0;
      short_q    <= 1'b0;
      overrun_q  <= 1'b0;
      csum_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      count_q    <= count_d;
      xor_q      <= xor_d;
      valid_q    <= valid_d;
      short_q    <= short_d;
      overrun_q  <= overrun_d;
      csum_err_q <= csum_err_d;
    end
  end

  // Next-state logic: byte collection, framing recovery and handshake.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    count_d    = count_q;
    xor_d      = xor_q;
    valid_d    = valid_q;
    short_d    = 1'b0;
    overrun_d  = 1'b0;
    csum_err_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (rx_data_ready) begin
          // A byte wins over a simultaneous end-of-packet strobe.
          shreg_d = {rx_data, shreg_q[PW-1:8]};
          count_d = count_q + CW'(1);
          xor_d   = xor_q ^ rx_data;
          if (count_q == LAST_IDX) begin
`ifdef RX_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = HOLD;
            valid_d = 1'b1;
`endif
          end else begin
            state_d = COLLECT;
          end
        end else if (rx_endofpacket && (count_q != {CW{1'b0}})) begin
          count_d = {CW{1'b0}};
          xor_d   = 8'h00;
          short_d = 1'b1;
        end else begin
          state_d = COLLECT;
        end
      end
`ifdef RX_CHECKSUM_EN
      CSUM: begin
        if (rx_data_ready) begin
          if (rx_data == xor_q) begin
            state_d = HOLD;
            valid_d = 1'b1;
            count_d = count_q + CW'(1);
          end else begin
            state_d    = COLLECT;
            count_d    = {CW{1'b0}};
            xor_d      = 8'h00;
            csum_err_d = 1'b1;
          end
        end else if (rx_endofpacket) begin
          state_d = COLLECT;
          count_d = {CW{1'b0}};
          xor_d   = 8'h00;
          short_d = 1'b1;
        end else begin
          state_d = CSUM;
        end
      end
`endif
      HOLD: begin
        // Any byte seen while holding is lost, even on the accept cycle.
        if (rx_data_ready) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = 1'b0;
        end
        if (valid_q && payload_ready) begin
          state_d = COLLECT;
          valid_d = 1'b0;
          count_d = {CW{1'b0}};
          xor_d   = 8'h00;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = COLLECT;
        valid_d = 1'b0;
        count_d = {CW{1'b0}};
        xor_d   = 8'h00;
      end
    endcase
  end

  assign payload_data  = shreg_q;
  assign payload_valid = valid_q;
  assign byte_count    = count_q;
  assign short_pkt     = short_q;
  assign overrun       = overrun_q;
  assign csum_error    = csum_err_q;

endmodule

// File: tb/tb_uart_rx_packet_assembler.sv
// Scoreboard bench for uart_rx_packet_assembler (N=4, default build).
module tb_uart_rx_packet_assembler;

  localparam int N  = 4;
  localparam int CW = $clog2(N + 2);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      rx_data;
  logic            rx_data_ready;
  logic            rx_endofpacket;
  logic [8*N-1:0]  payload_data;
  logic            payload_valid;
  logic            payload_ready;
  logic [CW-1:0]   byte_count;
  logic            short_pkt;
  logic            overrun;
  logic            csum_error;

  int n_total = 0;
  int n_bad   = 0;
  int short_seen = 0;
  int overrun_seen = 0;
  int csum_seen = 0;
  logic [31:0] exp_q[$];
  logic [31:0] held;

  uart_rx_packet_assembler #(.PAYLOAD_BYTES(N)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
    .rx_endofpacket(rx_endofpacket), .payload_data(payload_data),
    .payload_valid(payload_valid), .payload_ready(payload_ready),
    .byte_count(byte_count), .short_pkt(short_pkt), .overrun(overrun),
    .csum_error(csum_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected payload whenever a handshake completes.
  always @(negedge clk) begin
    if (short_pkt === 1'b1) short_seen++;
    if (overrun === 1'b1) overrun_seen++;
    if (csum_error === 1'b1) csum_seen++;
    if (payload_valid === 1'b1 && payload_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_payload: got %0h expected none", payload_data);
      end else begin
        check("payload", {32'd0, payload_data}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic eop = 1'b0);
    rx_data = b;
    rx_data_ready = 1'b1;
    rx_endofpacket = eop;
    step();
    rx_data_ready = 1'b0;
    rx_endofpacket = 1'b0;
  endtask

  task automatic send_eop();
    rx_endofpacket = 1'b1;
    step();
    rx_endofpacket = 1'b0;
  endtask

  task automatic accept();
    payload_ready = 1'b1;
    step();
    payload_ready = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] p);
    for (int i = 0; i < N; i++) begin
      logic [31:0] tmp;
      tmp = p >> (8 * i);
      send_byte(tmp[7:0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_data_ready = 1'b0;
    rx_endofpacket = 1'b0;
    payload_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    check("rst_valid", {63'd0, payload_valid}, 64'd0);
    check("rst_count", {61'd0, byte_count}, 64'd0);
    check("rst_data", {32'd0, payload_data}, 64'd0);
    check("rst_pulses", {61'd0, short_pkt, overrun, csum_error}, 64'd0);

    // Basic packet and latency of payload_valid.
    exp_q.push_back(32'h44332211);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("pre_valid", {63'd0, payload_valid}, 64'd0);
    check("count3", {61'd0, byte_count}, 64'd3);
    send_byte(8'h44);
    check("valid_lat1", {63'd0, payload_valid}, 64'd1);
    check("count4", {61'd0, byte_count}, 64'd4);
    check("data1", {32'd0, payload_data}, 64'h44332211);
    accept();
    check("acc_valid", {63'd0, payload_valid}, 64'd0);
    check("acc_count", {61'd0, byte_count}, 64'd0);

    // Back-pressure: payload held stable for 20 cycles.
    exp_q.push_back(32'h44332211);
    send_pkt(32'h44332211);
    for (int i = 0; i < 20; i++) begin
      check("hold_data", {32'd0, payload_data}, 64'h44332211);
      check("hold_valid", {63'd0, payload_valid}, 64'd1);
      step();
    end
    accept();
    check("acc2_valid", {63'd0, payload_valid}, 64'd0);
    check("acc2_count", {61'd0, byte_count}, 64'd0);

    // Short packet discard, then a good packet.
    send_byte(8'hA1); send_byte(8'hA2);
    send_eop();
    check("short_count", {61'd0, byte_count}, 64'd0);
    send_eop();   // idle end-of-packet at count 0: no pulse
    exp_q.push_back(32'h04030201);
    send_pkt(32'h04030201);
    check("data_after_short", {32'd0, payload_data}, 64'h04030201);
    accept();

    // Overrun while holding, end-of-packet ignored, byte on accept cycle dropped.
    exp_q.push_back(32'hDDCCBBAA);
    send_pkt(32'hDDCCBBAA);
    send_byte(8'hEE);
    send_byte(8'hFF);
    send_eop();
    check("ovr_data", {32'd0, payload_data}, 64'hDDCCBBAA);
    check("ovr_count", {61'd0, byte_count}, 64'd4);
    rx_data = 8'h99; rx_data_ready = 1'b1; payload_ready = 1'b1;
    step();
    rx_data_ready = 1'b0; payload_ready = 1'b0;
    check("ovr_acc_count", {61'd0, byte_count}, 64'd0);
    exp_q.push_back(32'h88776655);
    send_pkt(32'h88776655);
    check("post_ovr_data", {32'd0, payload_data}, 64'h88776655);
    accept();

    // Reset in the middle of a packet.
    send_byte(8'h01); send_byte(8'h02);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_count", {61'd0, byte_count}, 64'd0);
    check("mid_rst_data", {32'd0, payload_data}, 64'd0);
    check("mid_rst_valid", {63'd0, payload_valid}, 64'd0);
    exp_q.push_back(32'h40302010);
    send_pkt(32'h40302010);
    accept();

    // Byte and end-of-packet together: byte kept, no short pulse.
    // payload_ready while not valid has no effect.
    payload_ready = 1'b1;
    step();
    payload_ready = 1'b0;
    send_byte(8'hC1, 1'b1);
    check("eop_with_byte_count", {61'd0, byte_count}, 64'd1);
    exp_q.push_back(32'hC4C3C2C1);
    send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
    accept();
    step();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("short_pulses", 64'(short_seen), 64'd1);
    check("overrun_pulses", 64'(overrun_seen), 64'd3);
    check("csum_pulses", 64'(csum_seen), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
